// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier, W x W -> 2W, per-operation signed/unsigned mode.
// Latency: three register stages (capture/abs, partial products, accumulate/sign); one op per cycle.
// Backpressure: the whole pipe advances only when the output slot is empty or being consumed.

// Half adder cell.
module vedic_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// Full adder cell.
module vedic_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// Ripple-carry adder of full-adder cells; the top bit of s is the carry out.
module vedic_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   s
);
    logic [N:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g_bit
        vedic_fa u_fa (.x(a[i]), .y(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end
    assign s[N] = c[N];
endmodule

// 2x2 Vedic leaf: vertical and crosswise terms resolved with two half adders.
module vedic_mul2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c1;
    assign p[0] = a[0] & b[0];
    vedic_ha u_ha0 (.x(a[1] & b[0]), .y(a[0] & b[1]), .s(p[1]), .c(c1));
    vedic_ha u_ha1 (.x(a[1] & b[1]), .y(c1),          .s(p[2]), .c(p[3]));
endmodule

// 4x4 Vedic leaf: four 2x2 products combined with FA ripple adders.
module vedic_mul4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;
    logic [5:0] hi;

    vedic_mul2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic_mul2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic_mul2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic_mul2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

    vedic_rca #(.N(4)) u_mid (.a(q1), .b(q2), .s(mid));
    // Bits 7:2 = {q3,q0[3:2]} + mid; the sum never exceeds 6 bits, so bit 7 needs no carry out.
    vedic_rca #(.N(5)) u_hi (.a({q3[2:0], q0[3:2]}), .b(mid), .s(hi));

    assign p = {q3[3] ^ hi[5], hi[4:0], q0[1:0]};
endmodule

// Recursive Vedic multiplier, N a power of two >= 2.
module vedic_mul #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    localparam int H = N / 2;

    if (N == 2) begin : g_leaf2
        vedic_mul2 u_leaf (.a(a), .b(b), .p(p));
    end else if (N == 4) begin : g_leaf4
        vedic_mul4 u_leaf (.a(a), .b(b), .p(p));
    end else begin : g_rec
        logic [N-1:0] q_ll, q_hl, q_lh, q_hh;
        logic [N:0]   mid;
        vedic_mul #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(q_ll));
        vedic_mul #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(q_hl));
        vedic_mul #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(q_lh));
        vedic_mul #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(q_hh));
        assign mid = {1'b0, q_hl} + {1'b0, q_lh};
        assign p   = {q_hh, q_ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
    end
endmodule

// Top: three-stage valid/ready pipeline around the Vedic core.
// Latency: result valid on the third edge after acceptance; full throughput when out_ready is high.
// Backpressure: in_ready = !out_valid || out_ready, so a stalled output freezes every stage.
module vedic_mult_pipe #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           sgn,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic [1:0]     in_flight
);
    localparam int H = W / 2;

    logic           adv;
    logic [W-1:0]   ma_d, mb_d, ma_q, mb_q;
    logic           neg1_d, neg1_q, v1_q;
    logic [W-1:0]   hh_d, hl_d, lh_d, ll_d;
    logic [W-1:0]   hh_q, hl_q, lh_q, ll_q;
    logic           neg2_q, v2_q;
    logic [W:0]     mid;
    logic [2*W-1:0] mag, p_d, p_q;
    logic           ov_q;

    assign adv      = !ov_q || out_ready;
    assign in_ready = adv;

    // Two's-complement negation also maps -2^(W-1) onto its unsigned magnitude 2^(W-1).
    assign ma_d   = (sgn && a[W-1]) ? -a : a;
    assign mb_d   = (sgn && b[W-1]) ? -b : b;
    assign neg1_d = sgn && (a[W-1] ^ b[W-1]);

    vedic_mul #(.N(H)) u_hh (.a(ma_q[W-1:H]), .b(mb_q[W-1:H]), .p(hh_d));
    vedic_mul #(.N(H)) u_hl (.a(ma_q[W-1:H]), .b(mb_q[H-1:0]), .p(hl_d));
    vedic_mul #(.N(H)) u_lh (.a(ma_q[H-1:0]), .b(mb_q[W-1:H]), .p(lh_d));
    vedic_mul #(.N(H)) u_ll (.a(ma_q[H-1:0]), .b(mb_q[H-1:0]), .p(ll_d));

    assign mid = {1'b0, hl_q} + {1'b0, lh_q};
    assign mag = {hh_q, ll_q} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
    assign p_d = neg2_q ? -mag : mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_q   <= '0;
            mb_q   <= '0;
            neg1_q <= 1'b0;
            v1_q   <= 1'b0;
            hh_q   <= '0;
            hl_q   <= '0;
            lh_q   <= '0;
            ll_q   <= '0;
            neg2_q <= 1'b0;
            v2_q   <= 1'b0;
            p_q    <= '0;
            ov_q   <= 1'b0;
        end else if (adv) begin
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            neg1_q <= neg1_d;
            v1_q   <= in_valid;
            hh_q   <= hh_d;
            hl_q   <= hl_d;
            lh_q   <= lh_d;
            ll_q   <= ll_d;
            neg2_q <= neg1_q;
            v2_q   <= v1_q;
            // A bubble reaching S3 leaves the last product on out_p.
            if (v2_q) begin
                p_q <= p_d;
            end
            ov_q   <= v2_q;
        end
    end

    assign out_valid = ov_q;
    assign out_p     = p_q;
    assign in_flight = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, ov_q};
endmodule
